// File: rtl/fix_framer.sv
// FIX message framer: finds "8=" headers, forwards checksum-covered bytes through a
// two-byte delay line, strips the SOH "10=nnn" SOH trailer and reports its value.
module fix_framer #(
    parameter int MAX_LEN = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_i,
    input  logic       byte_valid_i,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    output logic       start_o,
    output logic       end_o,
    output logic [7:0] rcv_checksum_o,
    output logic       rcv_valid_o,
    output logic       err_o
);

    localparam int LW = $clog2(MAX_LEN + 2);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HDR    = 3'd1;
    localparam logic [2:0] ST_BODY   = 3'd2;
    localparam logic [2:0] ST_TRAIL  = 3'd3;
    localparam logic [2:0] ST_CKSUM0 = 3'd4;
    localparam logic [2:0] ST_CKSUM1 = 3'd5;
    localparam logic [2:0] ST_CKSUM2 = 3'd6;
    localparam logic [2:0] ST_TERM   = 3'd7;

    localparam logic [7:0] CH_SOH   = 8'h01;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_EIGHT = 8'h38;
    localparam logic [7:0] CH_ONE   = 8'h31;
    localparam logic [7:0] CH_ZERO  = 8'h30;

    logic [2:0]    state;
    logic [7:0]    s1, s2;
    logic          s1_valid, s2_valid;
    logic          last_soh;
    logic [LW-1:0] len;
    logic [9:0]    acc;

    logic [LW-1:0] len_next;
    logic          len_over;
    logic          is_digit;
    logic [9:0]    acc_next;
    logic          trailer_hit;
    logic          abort;

    always_comb begin
        // NOTE: every combinational signal gets a value on every path, so no latches appear.
        len_next    = len + LW'(1);
        len_over    = (len_next > LW'(MAX_LEN));
        is_digit    = (byte_i >= 8'h30) && (byte_i <= 8'h39);
        acc_next    = (acc << 3) + (acc << 1) + {6'd0, byte_i[3:0]};
        trailer_hit = (byte_i == CH_EQ) && s2_valid && (s2 == CH_ONE)
                   && s1_valid && (s1 == CH_ZERO) && last_soh;
        abort       = 1'b0;
        case (state)
            ST_HDR:    abort = (byte_i == CH_EQ) && len_over;
            ST_BODY:   abort = len_over;
            ST_CKSUM0,
            ST_CKSUM1,
            ST_CKSUM2: abort = !is_digit;
            ST_TERM:   abort = (byte_i != CH_SOH) || (acc > 10'd255);
            default:   abort = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: s1/s2 byte registers stay unreset; their valid bits alone gate their use.
            state          <= ST_IDLE;
            s1_valid       <= 1'b0;
            s2_valid       <= 1'b0;
            last_soh       <= 1'b0;
            len            <= '0;
            acc            <= '0;
            data_o         <= 8'h00;
            data_valid_o   <= 1'b0;
            start_o        <= 1'b0;
            end_o          <= 1'b0;
            rcv_checksum_o <= 8'h00;
            rcv_valid_o    <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments; pulses default low each cycle.
            data_valid_o <= 1'b0;
            start_o      <= 1'b0;
            end_o        <= 1'b0;
            rcv_valid_o  <= 1'b0;
            err_o        <= 1'b0;

            if (byte_valid_i && abort) begin
                err_o    <= 1'b1;
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
                last_soh <= 1'b0;
                acc      <= '0;
                state    <= ST_IDLE;
            end else if (byte_valid_i) begin
                case (state)
                    ST_IDLE: begin
                        if (byte_i == CH_EIGHT) begin
                            s1       <= byte_i;
                            s1_valid <= 1'b1;
                            s2_valid <= 1'b0;
                            last_soh <= 1'b0;
                            len      <= LW'(1);
                            state    <= ST_HDR;
                        end
                    end
                    ST_HDR: begin
                        if (byte_i == CH_EQ) begin
                            s2       <= s1;
                            s2_valid <= s1_valid;
                            s1       <= byte_i;
                            s1_valid <= 1'b1;
                            len      <= len_next;
                            start_o  <= 1'b1;
                            state    <= ST_BODY;
                        end else if (byte_i == CH_EIGHT) begin
                            s1       <= byte_i;
                            s1_valid <= 1'b1;
                            s2_valid <= 1'b0;
                            len      <= LW'(1);
                        end else begin
                            s1_valid <= 1'b0;
                            s2_valid <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end
                    ST_BODY: begin
                        len <= len_next;
                        if (trailer_hit) begin
                            // The held "1","0" and this "=" belong to the trailer and are dropped.
                            s1_valid <= 1'b0;
                            s2_valid <= 1'b0;
                            last_soh <= 1'b0;
                            acc      <= '0;
                            state    <= ST_CKSUM0;
                        end else begin
                            s2       <= s1;
                            s2_valid <= s1_valid;
                            s1       <= byte_i;
                            s1_valid <= 1'b1;
                            last_soh <= s2_valid && (s2 == CH_SOH);
                            if (s2_valid) begin
                                data_o       <= s2;
                                data_valid_o <= 1'b1;
                            end
                        end
                    end
                    ST_CKSUM0: begin
                        acc   <= acc_next;
                        state <= ST_CKSUM1;
                    end
                    ST_CKSUM1: begin
                        acc   <= acc_next;
                        state <= ST_CKSUM2;
                    end
                    ST_CKSUM2: begin
                        acc   <= acc_next;
                        state <= ST_TERM;
                    end
                    ST_TERM: begin
                        end_o          <= 1'b1;
                        rcv_valid_o    <= 1'b1;
                        rcv_checksum_o <= acc[7:0];
                        acc            <= '0;
                        state          <= ST_IDLE;
                    end
                    // ST_TRAIL is a reserved encoding that is never entered; it recovers to IDLE.
                    default: begin
                        s1_valid <= 1'b0;
                        s2_valid <= 1'b0;
                        state    <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fix_framer.sv
// Directed bench for fix_framer: a per-cycle vector table for the default instance plus a
// hand-written length-overflow sequence on a MAX_LEN=8 instance.
module tb_fix_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] byte_i;
    logic       byte_valid_i;

    logic [7:0] data_o, rcv_checksum_o;
    logic       data_valid_o, start_o, end_o, rcv_valid_o, err_o;
    logic [7:0] data8, ck8;
    logic       dv8, st8, en8, rv8, er8;

    always #5 clk = ~clk;

    fix_framer dut (
        .clk(clk), .rst(rst), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
        .data_o(data_o), .data_valid_o(data_valid_o), .start_o(start_o), .end_o(end_o),
        .rcv_checksum_o(rcv_checksum_o), .rcv_valid_o(rcv_valid_o), .err_o(err_o)
    );

    fix_framer #(.MAX_LEN(8)) dut8 (
        .clk(clk), .rst(rst), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
        .data_o(data8), .data_valid_o(dv8), .start_o(st8), .end_o(en8),
        .rcv_checksum_o(ck8), .rcv_valid_o(rv8), .err_o(er8)
    );

    typedef struct {
        logic       r;
        logic       v;
        logic [7:0] b;
        logic       dv;
        logic [7:0] d;
        logic       st, en, rv, er;
        logic [7:0] ck;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] cur_ck;
    int         checks = 0;
    int         passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push(input logic r, input logic v, input logic [7:0] b, input logic dv,
                        input logic [7:0] d, input logic st, input logic en,
                        input logic rv, input logic er);
        vec_t t;
        t.r = r; t.v = v; t.b = b; t.dv = dv; t.d = d;
        t.st = st; t.en = en; t.rv = rv; t.er = er; t.ck = cur_ck;
        vecs.push_back(t);
    endtask

    task automatic idle_b(input logic [7:0] b);                    push(1, 1, b, 0, 8'h00, 0, 0, 0, 0); endtask
    task automatic dat_b(input logic [7:0] b, input logic [7:0] d); push(1, 1, b, 1, d, 0, 0, 0, 0);     endtask
    task automatic st_b(input logic [7:0] b);                      push(1, 1, b, 0, 8'h00, 1, 0, 0, 0); endtask
    task automatic err_b(input logic [7:0] b);                     push(1, 1, b, 0, 8'h00, 0, 0, 0, 1); endtask
    task automatic gap();                                          push(1, 0, 8'h38, 0, 8'h00, 0, 0, 0, 0); endtask
    task automatic end_b(input logic [7:0] b, input logic [7:0] ck);
        cur_ck = ck;
        push(1, 1, b, 0, 8'h00, 0, 1, 1, 0);
    endtask
    task automatic rst_b();
        cur_ck = 8'h00;
        push(0, 1, 8'h38, 0, 8'h00, 0, 0, 0, 0);
    endtask

    // "8=" followed by SOH "10=" : trailer opens right after the header
    task automatic short_msg_head();
        idle_b("8"); st_b("="); dat_b(8'h01, 8'h38); dat_b("1", 8'h3D); dat_b("0", 8'h01); idle_b("=");
    endtask

    initial begin
        logic       exp_dv  [11];
        logic [7:0] exp_d   [11];
        logic       exp_er  [11];
        logic [7:0] stream8 [11];
        int         dv_count;

        rst = 1'b0; byte_valid_i = 1'b0; byte_i = 8'h00;
        cur_ck = 8'h00;

        // Reset state, with byte_valid_i held high to confirm reset priority
        rst_b(); rst_b();

        // Basic message with gaps: data 38 3D 58 01, checksum 123
        idle_b("8"); st_b("="); dat_b("X", 8'h38); gap(); gap(); dat_b(8'h01, 8'h3D);
        dat_b("1", 8'h58); dat_b("0", 8'h01); idle_b("="); idle_b("1"); idle_b("2"); gap();
        idle_b("3"); end_b(8'h01, 8'h7B);

        // Checksum 256 overflows the byte: error, checksum output keeps 0x7B
        idle_b("8"); st_b("="); dat_b("A", 8'h38); dat_b(8'h01, 8'h3D); dat_b("1", 8'h41);
        dat_b("0", 8'h01); idle_b("="); idle_b("2"); idle_b("5"); idle_b("6"); err_b(8'h01); gap();

        // "x10=5" without a preceding SOH is ordinary body data
        idle_b("8"); st_b("="); dat_b("x", 8'h38); dat_b("1", 8'h3D); dat_b("0", 8'h78);
        dat_b("=", 8'h31); dat_b("5", 8'h30); dat_b(8'h01, 8'h3D); dat_b("1", 8'h35);
        dat_b("0", 8'h01); idle_b("="); idle_b("0"); idle_b("0"); idle_b("0"); end_b(8'h01, 8'h00);

        // "88=" restarts the header and gives one start; checksum 090
        idle_b("8"); idle_b("8"); st_b("="); dat_b("Z", 8'h38); dat_b(8'h01, 8'h3D);
        dat_b("1", 8'h5A); dat_b("0", 8'h01); idle_b("="); idle_b("0"); idle_b("9"); idle_b("0");
        end_b(8'h01, 8'h5A);

        // "8A" abandons the header silently; the following "=" is dropped in IDLE
        idle_b("8"); idle_b("A"); idle_b("="); idle_b("B");

        // Reset during BODY, then a full message with 1-3 cycle gaps, checksum 255
        idle_b("8"); st_b("="); dat_b("Q", 8'h38); dat_b("R", 8'h3D); rst_b(); idle_b("="); idle_b("1");
        idle_b("8"); gap(); st_b("="); dat_b("K", 8'h38); gap(); gap(); gap(); dat_b(8'h01, 8'h3D);
        dat_b("1", 8'h4B); dat_b("0", 8'h01); idle_b("="); idle_b("2"); idle_b("5"); idle_b("5");
        gap(); end_b(8'h01, 8'hFF);

        // Non-digit in the checksum field, then idle bytes produce nothing
        short_msg_head(); idle_b("1"); err_b("A"); idle_b("B"); idle_b("=");

        // Wrong terminator after three digits
        short_msg_head(); idle_b("0"); idle_b("0"); idle_b("0"); err_b("X"); gap();

        // Clean message after an error, checksum 007
        short_msg_head(); idle_b("0"); idle_b("0"); idle_b("7"); end_b(8'h01, 8'h07);

        // Explicit reset values of every output, including data_o
        @(negedge clk); rst = 1'b0; byte_valid_i = 1'b1; byte_i = 8'h38;
        @(posedge clk); #1;
        check("reset_outputs",
              {7'd0, data_o, data_valid_o, start_o, end_o, rcv_checksum_o, rcv_valid_o, err_o},
              32'd0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].r; byte_valid_i = vecs[i].v; byte_i = vecs[i].b;
            @(posedge clk); #1;
            check($sformatf("vec%0d byte=%h", i, vecs[i].b),
                  {11'd0, data_valid_o, (data_valid_o ? data_o : 8'h00),
                   start_o, end_o, rcv_valid_o, err_o, rcv_checksum_o},
                  {11'd0, vecs[i].dv, (vecs[i].dv ? vecs[i].d : 8'h00),
                   vecs[i].st, vecs[i].en, vecs[i].rv, vecs[i].er, vecs[i].ck});
        end

        // MAX_LEN=8: "8=" + "abcdefghi"; the ninth message byte ('g') overflows
        stream8 = '{8'h38, 8'h3D, "a", "b", "c", "d", "e", "f", "g", "h", "i"};
        exp_dv  = '{0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        exp_d   = '{8'h00, 8'h00, 8'h38, 8'h3D, 8'h61, 8'h62, 8'h63, 8'h64, 8'h00, 8'h00, 8'h00};
        exp_er  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        @(negedge clk); rst = 1'b0; byte_valid_i = 1'b0;
        @(posedge clk); #1;
        dv_count = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk); rst = 1'b1; byte_valid_i = 1'b1; byte_i = stream8[i];
            @(posedge clk); #1;
            if (dv8) dv_count++;
            check($sformatf("maxlen8 byte%0d", i),
                  {21'd0, st8, dv8, (dv8 ? data8 : 8'h00), er8},
                  {21'd0, (i == 1) ? 1'b1 : 1'b0, exp_dv[i], exp_d[i], exp_er[i]});
        end
        check("maxlen8 data count", dv_count, 6);

        @(negedge clk); byte_valid_i = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fix_framer.md
FIX_FRAMER -- requirements
Module: fix_framer

Interface
REQ-001 The block SHALL have a parameter MAX_LEN, default 1024, giving the maximum accepted message length in bytes, counted from the leading '8' through the trailer '='.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change only on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: one clock; reset is synchronous and active-low.
REQ-004 The block SHALL have port byte_i, input, 8 bits: raw ASCII stream byte.
REQ-005 The block SHALL have port byte_valid_i, input, 1 bit: byte_i is accepted on this edge; there is no backpressure.
REQ-006 The block SHALL have port data_o, output, 8 bits: checksum-covered message byte.
REQ-007 The block SHALL have port data_valid_o, output, 1 bit: data_o is valid, one-cycle qualifier.
REQ-008 The block SHALL have port start_o, output, 1 bit: one-cycle pulse marking message start.
REQ-009 The block SHALL have port end_o, output, 1 bit: one-cycle pulse marking a complete, well-formed message.
REQ-010 The block SHALL have port rcv_checksum_o, output, 8 bits: binary value of the received "10=" field.
REQ-011 The block SHALL have port rcv_valid_o, output, 1 bit: rcv_checksum_o is updated, one-cycle pulse.
REQ-012 The block SHALL have port err_o, output, 1 bit: one-cycle pulse marking a framing error.

Function
REQ-013 All outputs SHALL be registered and SHALL update only in the cycle after an accepted byte.
REQ-014 The block SHALL hold a 2-stage byte delay line, s1 (newest) and s2, each with a valid bit.
REQ-015 On each accepted byte in HDR/BODY the block SHALL do all three of the following:
- shift s1 into s2;
- load byte_i into s1;
- emit the old s2, if valid, on data_o with data_valid_o=1.
REQ-016 The state machine SHALL have exactly the states IDLE, HDR, BODY, TRAIL, CKSUM0, CKSUM1, CKSUM2 and TERM.
REQ-017 IDLE: byte '8' (0x38) SHALL load s1, reset the length count to 1 and move to HDR; any other byte SHALL be dropped.
REQ-018 HDR handling SHALL be:
- '=' (0x3D): shift the line, pulse start_o, go to BODY;
- '8': restart HDR;
- anything else: clear the line and go to IDLE with no error.
REQ-019 BODY SHALL forward bytes per REQ-015 and SHALL track last_soh, set when the byte emitted from s2 equals 0x01.
REQ-020 Trailer detection, BODY: when byte_i='=' with s2='1', s1='0' and last_soh=1, the block SHALL do all of the following:
- invalidate s1 and s2;
- not emit '=';
- go to CKSUM0.
The '1', '0' and '=' SHALL never appear on data_o.
REQ-021 CKSUM0..2 SHALL each accept one ASCII digit 0x30-0x39 and accumulate acc = acc*10 + digit, using a 10-bit accumulator.
REQ-022 Any non-digit in CKSUM0..2 SHALL pulse err_o and return to IDLE.
REQ-023 TERM: byte 0x01 with acc<=255 SHALL pulse end_o and rcv_valid_o together and load rcv_checksum_o=acc[7:0].
REQ-024 TERM: any other byte, or acc>255, SHALL pulse err_o.
REQ-025 TERM SHALL go to IDLE in every case.
REQ-026 rcv_checksum_o SHALL hold its value until the next rcv_valid_o.
REQ-027 The length counter SHALL increment per accepted byte in HDR/BODY; if it exceeds MAX_LEN, the block SHALL pulse err_o, clear the line, and go to IDLE.
REQ-028 Any err_o SHALL clear the delay line and the accumulator.
REQ-029 No data_valid_o SHALL be produced between err_o and the next start_o.
REQ-030 start_o SHALL precede the first data_valid_o of its message by at least one cycle.
REQ-031 end_o SHALL follow the last data_valid_o of its message.
REQ-032 When byte_valid_i=0, the block SHALL hold all state, and all pulse outputs SHALL be 0 in the following cycle.

Reset
REQ-033 rst=0 at a clock edge SHALL do all of the following:
- force IDLE;
- clear s1/s2 valid, last_soh, the length counter and the accumulator;
- drive data_o=0x00, data_valid_o=0, start_o=0, end_o=0, rcv_checksum_o=0x00, rcv_valid_o=0, err_o=0.
REQ-034 Reset asserted mid-message SHALL discard the partial message with no end_o or err_o.
REQ-035 rst SHALL take priority over byte_valid_i.

Verification
REQ-036 Stream "8=X",0x01,"10=123",0x01 -> exactly one start_o, then data_o 0x38,0x3D,0x58,0x01 in order, then end_o, rcv_valid_o=1, rcv_checksum_o=123 (0x7B).
REQ-037 Field "10=256" followed by 0x01 -> err_o pulse, no end_o, rcv_checksum_o unchanged.
REQ-038 Body containing "x10=5" (no preceding SOH) -> those bytes are forwarded on data_o and no trailer is detected.
REQ-039 Stream "88=",... -> a single start_o; "8A" -> no start_o and return to IDLE.
REQ-040 With MAX_LEN=8, a 9-byte body with no trailer -> err_o on the 9th byte, after which data_valid_o stays low.
REQ-041 rst low for one cycle during BODY, then a full valid message -> only the second message produces end_o; byte_valid_i gaps of 1-3 cycles do not change the outputs.
